// File: rtl/jam_cost_server.sv
// Cost-table responder for the job-assignment solver: streams in an 8x8 cost
// table, serves zero-latency lookups, and supervises one solver run.
module jam_cost_server #(
  parameter int unsigned CW      = 7,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          load_valid,
  input  logic [CW-1:0] load_data,
  output logic          load_ready,
  input  logic [2:0]    W,
  input  logic [2:0]    J,
  output logic [CW-1:0] Cost,
  output logic          solver_rst,
  input  logic          Valid,
  input  logic [9:0]    MinCost,
  input  logic [3:0]    MatchCount,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [9:0]    res_min_cost,
  output logic [3:0]    res_match_count,
  output logic [31:0]   run_cycles
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [31:0] LP_LAST_CYCLE = 32'(TIMEOUT - 1);

  state_t        r_state, w_next;
  logic [5:0]    r_wr_ptr;
  logic [CW-1:0] r_table [64];
  logic          r_solver_rst, r_done, r_timeout;
  logic [9:0]    r_res_min_cost;
  logic [3:0]    r_res_match_count;
  logic [31:0]   r_run_cycles;

  logic w_load_fire, w_last_word, w_timeout_hit;

  assign w_load_fire   = (r_state == LOAD) && load_valid;
  assign w_last_word   = w_load_fire && (r_wr_ptr == 6'd63);
  assign w_timeout_hit = (r_run_cycles == LP_LAST_CYCLE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_next = LOAD;
      LOAD:       if (w_last_word) w_next = RUN;
      RUN:        if (Valid || w_timeout_hit) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr          <= '0;
      r_solver_rst      <= 1'b1;
      r_done            <= 1'b0;
      r_timeout         <= 1'b0;
      r_res_min_cost    <= '0;
      r_res_match_count <= '0;
      r_run_cycles      <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_wr_ptr          <= '0;
            r_done            <= 1'b0;
            r_timeout         <= 1'b0;
            r_res_min_cost    <= '0;
            r_res_match_count <= '0;
            r_run_cycles      <= '0;
          end
        end
        LOAD: begin
          if (w_load_fire) r_wr_ptr <= r_wr_ptr + 6'd1;
          if (w_last_word) r_solver_rst <= 1'b0;
        end
        RUN: begin
          r_run_cycles <= r_run_cycles + 32'd1;
          // Valid takes priority over a coincident timeout.
          if (Valid) begin
            r_res_min_cost    <= MinCost;
            r_res_match_count <= MatchCount;
            r_solver_rst      <= 1'b1;
            r_done            <= 1'b1;
          end else if (w_timeout_hit) begin
            r_timeout    <= 1'b1;
            r_solver_rst <= 1'b1;
            r_done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && w_load_fire) r_table[r_wr_ptr] <= load_data;
  end

  assign Cost            = r_table[{W, J}];
  assign load_ready      = (r_state == LOAD);
  assign busy            = (r_state == LOAD) || (r_state == RUN);
  assign solver_rst      = r_solver_rst;
  assign done            = r_done;
  assign timeout         = r_timeout;
  assign res_min_cost    = r_res_min_cost;
  assign res_match_count = r_res_match_count;
  assign run_cycles      = r_run_cycles;

endmodule

// File: tb/tb_jam_cost_server.sv
// Directed bench for jam_cost_server with a shortened TIMEOUT of 100 cycles.
module tb_jam_cost_server;

  logic        CLK = 1'b0;
  logic        RST, start, load_valid, Valid;
  logic [6:0]  load_data;
  logic        load_ready, solver_rst, busy, done, timeout;
  logic [2:0]  W, J;
  logic [6:0]  Cost;
  logic [9:0]  MinCost, res_min_cost;
  logic [3:0]  MatchCount, res_match_count;
  logic [31:0] run_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  jam_cost_server #(.CW(7), .TIMEOUT(100)) dut (
    .CLK(CLK), .RST(RST), .start(start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .W(W), .J(J), .Cost(Cost),
    .solver_rst(solver_rst), .Valid(Valid), .MinCost(MinCost),
    .MatchCount(MatchCount), .busy(busy), .done(done), .timeout(timeout),
    .res_min_cost(res_min_cost), .res_match_count(res_match_count),
    .run_cycles(run_cycles)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] word(input int k, input int mode);
    case (mode)
      0:       word = 7'(k % 100);
      1:       word = 7'(127 - k);
      2:       word = 7'(k);
      default: word = 7'((k + 7) % 128);
    endcase
  endfunction

  // Presents words first..first+n-1; a word is consumed only on a handshake.
  task automatic load_words(input int first, input int n, input int mode, input bit gaps);
    int sent = 0;
    int cyc  = 0;
    while (sent < n && cyc < 400) begin
      load_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
      load_data  = word(first + sent, mode);
      if (load_valid && load_ready) sent++;
      step();
      cyc++;
    end
    load_valid = 1'b0;
    check("load_handshakes", sent, n);
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int sum;
    RST = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0;
    Valid = 1'b0; MinCost = '0; MatchCount = '0; W = '0; J = '0;
    step(3);
    RST = 1'b0;
    step(5);

    // 1: reset/idle values
    check("rst_solver_rst", solver_rst, 1);
    check("rst_load_ready", load_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_run_cycles", run_cycles, 0);

    // 2: full load, k mod 100
    kick();
    check("load_ready_in_load", load_ready, 1);
    check("busy_in_load", busy, 1);
    load_words(0, 64, 0, 1'b0);
    check("t2_solver_rst_run", solver_rst, 0);
    check("t2_load_ready_run", load_ready, 0);
    W = 3'd3; J = 3'd5; #1;
    check("t2_cost_3_5", Cost, 29);
    W = 3'd7; J = 3'd7; #1;
    check("t2_cost_7_7", Cost, 63);
    step(110);
    check("t2_timeout", timeout, 1);

    // 3: gapped load then extra words during RUN
    kick();
    load_words(0, 64, 1, 1'b1);
    check("t3_load_ready_run", load_ready, 0);
    check("t3_run_cycles0", run_cycles, 0);
    load_valid = 1'b1; load_data = 7'h55;
    step(3);
    load_valid = 1'b0;
    W = 3'd0; J = 3'd0; #1;
    check("t3_table0_kept", Cost, 127);
    W = 3'd7; J = 3'd7; #1;
    check("t3_table63", Cost, 64);

    // 4: Valid after 20 RUN cycles
    step(17);
    check("t4_run_cycles20", run_cycles, 20);
    check("t4_done_before", done, 0);
    Valid = 1'b1; MinCost = 10'd123; MatchCount = 4'd2;
    step();
    Valid = 1'b0;
    check("t4_done", done, 1);
    check("t4_timeout", timeout, 0);
    check("t4_res_min", res_min_cost, 123);
    check("t4_res_match", res_match_count, 2);
    check("t4_solver_rst", solver_rst, 1);
    check("t4_run_cycles", run_cycles, 21);
    check("t4_busy", busy, 0);
    Valid = 1'b1; MinCost = 10'd999; MatchCount = 4'd9;
    step(2);
    Valid = 1'b0;
    check("t4_res_min_held", res_min_cost, 123);
    check("t4_run_cycles_held", run_cycles, 21);

    // 5a: timeout with no Valid
    kick();
    check("t5_clear_done", done, 0);
    check("t5_clear_res", res_min_cost, 0);
    load_words(0, 64, 2, 1'b0);
    step(99);
    check("t5_no_done_yet", done, 0);
    step();
    check("t5_done", done, 1);
    check("t5_timeout", timeout, 1);
    check("t5_run_cycles", run_cycles, 100);
    check("t5_res_min", res_min_cost, 0);
    check("t5_res_match", res_match_count, 0);
    check("t5_solver_rst", solver_rst, 1);

    // 5b: Valid coinciding with the last permitted cycle
    kick();
    check("t5b_timeout_cleared", timeout, 0);
    load_words(0, 64, 2, 1'b0);
    step(99);
    check("t5b_run_cycles99", run_cycles, 99);
    Valid = 1'b1; MinCost = 10'd77; MatchCount = 4'd5;
    step();
    Valid = 1'b0;
    check("t5b_done", done, 1);
    check("t5b_timeout", timeout, 0);
    check("t5b_res_min", res_min_cost, 77);
    check("t5b_res_match", res_match_count, 5);
    check("t5b_run_cycles", run_cycles, 100);

    // 6: reset mid-load, then a fresh load and a diagonal-sum solver
    kick();
    load_words(0, 10, 0, 1'b0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t6_rst_load_ready", load_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_solver_rst", solver_rst, 1);
    kick();
    load_words(0, 63, 3, 1'b0);
    check("t6_still_loading", load_ready, 1);
    check("t6_solver_held", solver_rst, 1);
    load_words(63, 1, 3, 1'b0);
    check("t6_solver_released", solver_rst, 0);
    W = 3'd0; J = 3'd0; #1;
    check("t6_entry0", Cost, 7);
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      W = 3'(i); J = 3'(i);
      #1;
      sum += int'(Cost);
      step();
    end
    check("t6_solver_sum", sum, 308);
    Valid = 1'b1; MinCost = 10'(sum); MatchCount = 4'd1;
    step();
    Valid = 1'b0;
    check("t6_done", done, 1);
    check("t6_res_min", res_min_cost, 308);
    check("t6_timeout", timeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
- Responder side of the worker/job cost-lookup interface used by the exhaustive job-assignment solver.
- Holds an 8x8 cost table that is loaded over a valid/ready stream.
- Answers solver W/J lookups with Cost in the same cycle, and holds the solver in reset until the table is fully loaded.
- Captures MinCost/MatchCount when the solver pulses Valid; reports done or timeout to the host.

Parameters:
- CW, 7: cost entry width in bits.
- TIMEOUT, 1000000: maximum RUN cycles before the run is aborted.

Ports:
- CLK  input  1  clock
- RST  input  1  reset; synchronous, active-high
- start  input  1  host request to begin load+run; sampled only in IDLE or DONE
- load_valid  input  1  load word valid
- load_data  input  CW  cost entry; entries arrive row-major, entry k goes to worker k[5:3], job k[2:0]
- load_ready  output  1  block accepts a load word
- W  input  3  worker index from solver
- J  input  3  job index from solver
- Cost  output  CW  table[{W,J}]
- solver_rst  output  1  synchronous reset to the solver
- Valid  input  1  solver result strobe
- MinCost  input  10  solver minimum cost
- MatchCount  input  4  solver match count
- busy  output  1  state is LOAD or RUN
- done  output  1  run finished; held until next start
- timeout  output  1  run ended by TIMEOUT, not by Valid
- res_min_cost  output  10  captured MinCost
- res_match_count  output  4  captured MatchCount
- run_cycles  output  32  cycles spent in RUN

Behaviour:
- Reset values:
  - state = IDLE, wr_ptr = 0.
  - load_ready = 0, solver_rst = 1, busy = 0, done = 0, timeout = 0.
  - res_min_cost = 0, res_match_count = 0, run_cycles = 0.
  - Table contents are not reset.
- Cost is a combinational read of table[{W,J}] in every state. Zero latency: the solver accumulates Cost in the cycle W/J are presented.
- States:
  - IDLE:
    - start=1 -> LOAD.
    - On that edge: wr_ptr <= 0, done <= 0, timeout <= 0, res_* <= 0, run_cycles <= 0.
  - LOAD:
    - load_ready = 1 (combinational from state).
    - Each cycle with load_valid && load_ready: table[wr_ptr] <= load_data, wr_ptr <= wr_ptr + 1.
    - The handshake at wr_ptr==63 -> RUN, and solver_rst <= 0 on that edge.
    - load_valid gaps are allowed.
    - start is ignored.
  - RUN:
    - load_ready = 0; extra load words are ignored and not written.
    - run_cycles increments every cycle.
    - Valid=1 -> DONE. On that edge: res_min_cost <= MinCost, res_match_count <= MatchCount, solver_rst <= 1, done <= 1.
    - Else if run_cycles == TIMEOUT-1 -> DONE with timeout <= 1, done <= 1, solver_rst <= 1, res_* unchanged (0).
    - If Valid and the timeout condition occur in the same cycle, Valid wins: timeout stays 0 and results are captured.
    - start is ignored.
  - DONE:
    - done = 1 and outputs are held.
    - start=1 -> LOAD with the same clears as from IDLE; the table is reloaded from entry 0.
- Valid outside RUN is ignored.
- solver_rst is registered. It is 1 in every state except RUN, so the solver sees at least one reset edge before each run and restarts from its initial permutation.
- busy is combinational: state in {LOAD, RUN}.
- RST in any state returns the block to IDLE with reset values.
  - A partial load is discarded logically; wr_ptr restarts at 0 on the next start.
  - RST during RUN reasserts solver_rst immediately at that edge.
- run_cycles never reaches wrap in practice (bounded by TIMEOUT); it is a 32-bit plain counter.

Test Plan:
1. Reset then idle 5 cycles -> solver_rst=1, load_ready=0, busy=0, done=0, timeout=0, run_cycles=0.
2. start, load 64 words with data k mod 100 -> RUN entered after the 64th handshake, solver_rst=0 next cycle. Then W=3, J=5 -> Cost=29; W=7, J=7 -> Cost=63.
3. Load with load_valid deasserted every other cycle, then 3 extra valid words presented in RUN -> exactly 64 writes, load_ready=0 in RUN, table[0] unchanged by the extra words.
4. In RUN, after 20 cycles, pulse Valid with MinCost=123, MatchCount=2 -> next cycle:
   - done=1, timeout=0, res_min_cost=123, res_match_count=2, solver_rst=1, run_cycles=21.
   - Further Valid pulses are ignored.
5. TIMEOUT=100 and Valid never asserted -> done=1, timeout=1, run_cycles=100, res_*=0. Repeat with Valid asserted in the 100th RUN cycle -> timeout=0, results captured.
6. RST after 10 load words, then start and a full 64-word load -> entry 0 holds the new first word, RUN is entered only after 64 new handshakes; solver attached end-to-end completes with Valid and matching captured MinCost.
